// File: rtl/softmax_pkg.sv
// Shared definitions for the logits MAC front end and the 4-way softmax stage.
package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int LOGIT_W   = 16;
    localparam int LOGIT_MAX = 65535;
    localparam int Q88_ONE   = 256;

endpackage

// File: rtl/logits_mac_4_mac_lane.sv
// One class lane: signed 8x8 MAC into a wide accumulator, then shift, ReLU and
// unsigned saturation into a registered Q8.8 logit.
module mac_lane
    import softmax_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int SHIFT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               acc_en_i,
    input  logic               load_i,
    input  logic [7:0]         x_i,
    input  logic [7:0]         w_i,
    output logic [LOGIT_W-1:0] logit_o
);

    localparam logic signed [ACC_W-1:0] LOGIT_MAX_ACC = ACC_W'(LOGIT_MAX);

    logic signed [15:0]        prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   shifted;
    logic [LOGIT_W-1:0]        sat;
    logic [LOGIT_W-1:0]        logit_q, logit_d;

    assign prod     = $signed(x_i) * $signed(w_i);
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    assign shifted  = acc_q >>> SHIFT;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        acc_d   = acc_q;
        logit_d = logit_q;
        sat     = shifted[LOGIT_W-1:0];
        if (shifted < 0) begin
            sat = '0;
        end else if (shifted > LOGIT_MAX_ACC) begin
            sat = LOGIT_W'(LOGIT_MAX);
        end
        if (clear_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + prod_ext;
        end
        if (load_i) begin
            logit_d = sat;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            logit_q <= '0;
        end else begin
            acc_q   <= acc_d;
            logit_q <= logit_d;
        end
    end

    assign logit_o = logit_q;

endmodule

// File: rtl/logits_mac_4.sv
// Four-class dot-product engine producing Q8.8 logits for the softmax stage;
// owns the control FSM, the beat counter and the activation handshake.
module logits_mac_4
    import softmax_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int SHIFT   = 0,
    parameter int ACC_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        x_valid,
    output logic        x_ready,
    input  logic [7:0]  x_data,
    input  logic [7:0]  w0,
    input  logic [7:0]  w1,
    input  logic [7:0]  w2,
    input  logic [7:0]  w3,
    output logic [15:0] logit0,
    output logic [15:0] logit1,
    output logic [15:0] logit2,
    output logic [15:0] logit3,
    output logic        logit_valid,
    output logic        busy
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clear, acc_en, load, beat;
    logic [7:0]         w_arr     [4];
    logic [LOGIT_W-1:0] logit_arr [4];

    assign beat = x_valid && x_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        acc_en  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_SCALE;
                    end
                end
            end
            ST_SCALE: begin
                load    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake and status decode straight from the state register, so they
    // come out of reset low without extra flops.
    assign x_ready     = (state_q == ST_ACC);
    assign logit_valid = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);

    assign w_arr[0] = w0;
    assign w_arr[1] = w1;
    assign w_arr[2] = w2;
    assign w_arr[3] = w3;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        mac_lane #(
            .ACC_W (ACC_W),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear_i  (clear),
            .acc_en_i (acc_en),
            .load_i   (load),
            .x_i      (x_data),
            .w_i      (w_arr[g]),
            .logit_o  (logit_arr[g])
        );
    end

    assign logit0 = logit_arr[0];
    assign logit1 = logit_arr[1];
    assign logit2 = logit_arr[2];
    assign logit3 = logit_arr[3];

endmodule
